// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
package debounce_pkg;

  // Two stable levels, each with a qualification state guarding entry to the other.
  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } state_e;

  // Legal input synchronizer depth range.
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

endpackage

// File: rtl/debounce_timer.sv
// Settle timer: N-bit up counter, synchronous clear beats enable,
// done flags that bit N-1 has been reached.
module debounce_timer #(
  parameter int N = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic sclr,
  input  logic en,
  output logic done
);

  logic [N-1:0] count_q, count_d;

  // Next count: clear has priority, otherwise advance on enable.
  always_comb begin
    count_d = count_q;
    if (sclr)    count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done = count_q[N-1];

endmodule

// File: rtl/debounce_ctrl.sv
// Switch debouncer: synchronizer chain, four-state qualify FSM and one settle
// timer. A level change must hold for 2^(N-1) ticks before db_out follows it.
// Macro DEBOUNCE_EDGE_PULSE_EN enables the registered press/release pulses;
// when undefined both pulses are tied low and their logic is absent.
// The release pulse port is named release_pulse because 'release' is a
// reserved word in SystemVerilog.
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int N           = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic tick,
  output logic db_out,
  output logic press,
  output logic release_pulse,
  output logic busy
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("debounce_ctrl: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  state_e                 state_q, state_d;
  logic                   db_q, db_d;
  logic                   busy_q, busy_d;
  logic                   tmr_sclr, tmr_en, tmr_done;

  // Synchronizer chain shifts btn_in in at bit 0; the top bit is the clean level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Next state and timer control; a revert of sync outranks timer expiry so a
  // glitch ending exactly at the settle boundary still leaves db_out unchanged.
  always_comb begin
    state_d  = state_q;
    tmr_sclr = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      S_LOW: begin
        tmr_sclr = 1'b1;
        if (sync) state_d = S_CHK_HIGH;
      end
      S_CHK_HIGH: begin
        if (!sync) begin
          state_d  = S_LOW;
          tmr_sclr = 1'b1;
        end else if (tmr_done) begin
          state_d = S_HIGH;
        end else begin
          tmr_en = tick;
        end
      end
      S_HIGH: begin
        tmr_sclr = 1'b1;
        if (!sync) state_d = S_CHK_LOW;
      end
      S_CHK_LOW: begin
        if (sync) begin
          state_d  = S_HIGH;
          tmr_sclr = 1'b1;
        end else if (tmr_done) begin
          state_d = S_LOW;
        end else begin
          tmr_en = tick;
        end
      end
      default: begin
        state_d  = S_LOW;
        tmr_sclr = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    db_d   = (state_d == S_HIGH)     || (state_d == S_CHK_LOW);
    busy_d = (state_d == S_CHK_HIGH) || (state_d == S_CHK_LOW);
  end

  // State, synchronizer and level/busy output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_LOW;
      db_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      db_q    <= db_d;
      busy_q  <= busy_d;
    end
  end

  debounce_timer #(.N(N)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .sclr (tmr_sclr),
    .en   (tmr_en),
    .done (tmr_done)
  );

  assign db_out = db_q;
  assign busy   = busy_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic press_q, press_d;
  logic rel_q, rel_d;

  // Edge pulses land on the same edge that db_out changes.
  always_comb begin
    press_d = db_d & ~db_q;
    rel_d   = ~db_d & db_q;
  end

  // Pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign press         = press_q;
  assign release_pulse = rel_q;
`else
  assign press         = 1'b0;
  assign release_pulse = 1'b0;
`endif

endmodule

// File: doc/debounce_ctrl.md
DEBOUNCE_CTRL -- requirements
Module: debounce_ctrl

Interface
REQ-001 Parameter N, default 11, settle-timer width; the settle time is 2^(N-1) ticks.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth, legal values 2..4.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_in  input  1  raw asynchronous switch level.
REQ-006 tick  input  1  timer advance strobe (shared prescaler); tie to 1 for every-cycle counting.
REQ-007 db_out  output  1  debounced level, registered.
REQ-008 press  output  1  one-cycle pulse on the db_out 0->1 transition.
REQ-009 release  output  1  one-cycle pulse on the db_out 1->0 transition.
REQ-010 busy  output  1  high while a level change is being qualified.

Function
REQ-011 btn_in SHALL pass through a SYNC_STAGES flop chain; sync denotes the last stage.
REQ-012 FSM states SHALL be: S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW.
REQ-013 In S_LOW with sync=1, the next state SHALL be S_CHK_HIGH and the timer SHALL be cleared.
REQ-014 In S_CHK_HIGH, the timer SHALL increment by 1 on each cycle with tick=1 and hold when tick=0.
REQ-015 In S_CHK_HIGH with sync=0, the next state SHALL be S_LOW and the timer SHALL be cleared.
REQ-016 In S_CHK_HIGH with timer bit N-1 set and sync=1, the next state SHALL be S_HIGH.
REQ-017 S_HIGH, S_CHK_LOW: mirror of REQ-013..016 with the sync polarity inverted.
REQ-018 When sync reverts in the same cycle as timer bit N-1 is set, the revert SHALL win and db_out SHALL be unchanged.
REQ-019 db_out SHALL be 1 exactly in S_HIGH and S_CHK_LOW.
REQ-020 busy SHALL be 1 exactly in S_CHK_HIGH and S_CHK_LOW.
REQ-021 Latency with tick=1: a btn_in edge that is stable thereafter SHALL reach db_out after exactly SYNC_STAGES+2+2^(N-1) rising edges.
REQ-022 The timer SHALL saturate conceptually; it is never used beyond bit N-1 because the state exits first, so there is no wrap-around.
REQ-023 Glitches shorter than 2^(N-1) ticks SHALL never change db_out and SHALL never produce press or release.

Reset
REQ-024 While rst=1, the block SHALL hold: state=S_LOW, timer=0, sync chain=0, db_out=0, press=0, release=0, busy=0.
REQ-025 Reset asserted mid-qualification SHALL abort it immediately, without a pulse.
REQ-026 If btn_in is high at reset release, the block SHALL qualify it through S_CHK_HIGH normally and assert press once.

Configuration
REQ-027 Macro DEBOUNCE_EDGE_PULSE_EN:
- Defined: press and release SHALL be registered one-cycle pulses, coincident with the db_out change.
- Undefined: press and release SHALL be constant 0 and their logic SHALL be omitted.

Structure
REQ-028 Package debounce_pkg SHALL hold the state enum and the SYNC_STAGES legal-range constants.
REQ-029 Sub-module debounce_timer SHALL provide:
- Ports: clk, rst, sclr, en.
- N-bit count; sclr has priority over en.
- Output done = count[N-1].
- debounce_ctrl SHALL instantiate it once.

Verification (N=4, SYNC_STAGES=2, tick=1 unless stated)
REQ-030 Reset release, btn_in=0 held -> db_out=0, busy=0, no pulses for 50 cycles.
REQ-031 btn_in 0->1 held -> db_out=1 exactly 12 edges later, press high for that one cycle only, busy high for 9 cycles before it.
REQ-032 btn_in high for 5 cycles then low -> db_out stays 0, no press; busy returns to 0.
REQ-033 tick pulsed every 3rd cycle, btn_in 1->0 from S_HIGH -> db_out=0 after 2+1+24 edges, release pulsed once.
REQ-034 rst asserted 4 cycles into S_CHK_HIGH -> all outputs 0 asynchronously; after release with btn_in=1, full 12-edge qualification and one press.
REQ-035 Macro undefined, repeat REQ-031 -> identical db_out timing, press and release always 0.
